// File: rtl/txr_write_packetizer_if.sv
// Bus bundle for txr_write_packetizer: descriptor, payload and TXR packet streams.
// The WR_REQ_IS_READ signal exists only when TXR_PACKETIZER_READ_REQ_EN is defined.
interface txr_write_packetizer_if;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned LEN_W  = 10;

  logic              WR_REQ_VALID;
  logic              WR_REQ_READY;
  logic [ADDR_W-1:0] WR_REQ_ADDR;
  logic [LEN_W-1:0]  WR_REQ_LEN;
  logic [7:0]        WR_REQ_TAG;
  logic [3:0]        WR_REQ_FBE;
  logic [3:0]        WR_REQ_LBE;
`ifdef TXR_PACKETIZER_READ_REQ_EN
  logic              WR_REQ_IS_READ;
`endif
  logic [DATA_W-1:0] WR_DATA;
  logic              WR_DATA_VALID;
  logic              WR_DATA_READY;
  logic [DATA_W-1:0] TXR_PKT;
  logic              TXR_PKT_VALID;
  logic              TXR_PKT_READY;
  logic              TXR_PKT_START_FLAG;
  logic [1:0]        TXR_PKT_START_OFFSET;
  logic              TXR_PKT_END_FLAG;
  logic [1:0]        TXR_PKT_END_OFFSET;
  logic              BUSY;

  // Requester / packet-sink side
  modport master (
`ifdef TXR_PACKETIZER_READ_REQ_EN
    output WR_REQ_IS_READ,
`endif
    output WR_REQ_VALID, WR_REQ_ADDR, WR_REQ_LEN, WR_REQ_TAG, WR_REQ_FBE, WR_REQ_LBE,
    output WR_DATA, WR_DATA_VALID, TXR_PKT_READY,
    input  WR_REQ_READY, WR_DATA_READY, TXR_PKT, TXR_PKT_VALID, TXR_PKT_START_FLAG,
    input  TXR_PKT_START_OFFSET, TXR_PKT_END_FLAG, TXR_PKT_END_OFFSET, BUSY
  );

  // Packetizer side
  modport slave (
`ifdef TXR_PACKETIZER_READ_REQ_EN
    input  WR_REQ_IS_READ,
`endif
    input  WR_REQ_VALID, WR_REQ_ADDR, WR_REQ_LEN, WR_REQ_TAG, WR_REQ_FBE, WR_REQ_LBE,
    input  WR_DATA, WR_DATA_VALID, TXR_PKT_READY,
    output WR_REQ_READY, WR_DATA_READY, TXR_PKT, TXR_PKT_VALID, TXR_PKT_START_FLAG,
    output TXR_PKT_START_OFFSET, TXR_PKT_END_FLAG, TXR_PKT_END_OFFSET, BUSY
  );
endinterface

// File: rtl/txr_write_packetizer.sv
// Write-request packetizer: turns a descriptor plus payload stream into a TXR
// packet (one 4-DW header beat followed by payload beats) behind a single
// output register. Optional read descriptors (header-only packets) are enabled
// by defining TXR_PACKETIZER_READ_REQ_EN.
module txr_write_packetizer #(
  parameter int unsigned C_PCI_DATA_WIDTH = 128,
  parameter int unsigned C_MAX_LEN_DW     = 1024,
  parameter logic [15:0] C_REQUESTER_ID   = 16'h0000
) (
  input logic                   CLK,
  input logic                   RST_N,
  txr_write_packetizer_if.slave bus
);
  localparam int unsigned CNT_W          = 11;
  localparam int unsigned UPKT_TXR_FBE_I = 104;
  localparam int unsigned UPKT_TXR_LBE_I = 108;
  localparam int unsigned FBE_POS        = UPKT_TXR_FBE_I % C_PCI_DATA_WIDTH;
  localparam int unsigned LBE_POS        = UPKT_TXR_LBE_I % C_PCI_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, HDR, DATA} stateT;

  stateT                       stateQ, stateD;
  logic [CNT_W-1:0]            remQ, remD;
  logic                        isReadQ, isReadD;
  logic                        rstDoneQ;
  logic [C_PCI_DATA_WIDTH-1:0] pktQ, pktD, hdr;
  logic                        validQ, validD;
  logic                        startQ, startD;
  logic                        endQ, endD;
  logic [1:0]                  endOffQ, endOffD;

  logic canLoad, reqReady, dataReady, reqFire, dataFire, lastBeat, reqIsRead;

`ifdef TXR_PACKETIZER_READ_REQ_EN
  assign reqIsRead = bus.WR_REQ_IS_READ;
`else
  assign reqIsRead = 1'b0;
`endif

  // Handshake decode around the single output register
  assign canLoad   = !validQ || bus.TXR_PKT_READY;
  assign reqReady  = rstDoneQ && (stateQ == IDLE) && canLoad;
  assign dataReady = ((stateQ == HDR) || (stateQ == DATA)) && !isReadQ && canLoad;
  assign reqFire   = bus.WR_REQ_VALID && reqReady;
  assign dataFire  = bus.WR_DATA_VALID && dataReady;
  assign lastBeat  = (remQ <= CNT_W'(4));

  // Header beat assembled straight from the descriptor inputs
  always_comb begin
    hdr                 = '0;
    hdr[63:0]           = bus.WR_REQ_ADDR & ~64'h3;
    hdr[74:64]          = CNT_W'(bus.WR_REQ_LEN);
    hdr[78:75]          = reqIsRead ? 4'b0000 : 4'b0001;
    hdr[95:80]          = C_REQUESTER_ID;
    hdr[103:96]         = bus.WR_REQ_TAG;
    hdr[FBE_POS +: 4]   = bus.WR_REQ_FBE;
    hdr[LBE_POS +: 4]   = (bus.WR_REQ_LEN == 10'd1) ? 4'b0000 : bus.WR_REQ_LBE;
  end

  // State, counter and output register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stateQ   <= IDLE;
      remQ     <= '0;
      isReadQ  <= 1'b0;
      rstDoneQ <= 1'b0;
      pktQ     <= '0;
      validQ   <= 1'b0;
      startQ   <= 1'b0;
      endQ     <= 1'b0;
      endOffQ  <= 2'd0;
    end else begin
      stateQ   <= stateD;
      remQ     <= remD;
      isReadQ  <= isReadD;
      rstDoneQ <= 1'b1;
      pktQ     <= pktD;
      validQ   <= validD;
      startQ   <= startD;
      endQ     <= endD;
      endOffQ  <= endOffD;
    end
  end

  // Next-state and remaining-DW counter
  always_comb begin
    stateD  = stateQ;
    remD    = remQ;
    isReadD = isReadQ;
    unique case (stateQ)
      IDLE: begin
        if (reqFire) begin
          stateD  = HDR;
          remD    = (bus.WR_REQ_LEN == '0) ? CNT_W'(C_MAX_LEN_DW) : CNT_W'(bus.WR_REQ_LEN);
          isReadD = reqIsRead;
        end
      end
      HDR: begin
        // Header leaves when the register can load; first data beat may load alongside
        if (canLoad) begin
          if (isReadQ || (dataFire && lastBeat)) stateD = IDLE;
          else                                   stateD = DATA;
        end
      end
      DATA: begin
        if (dataFire && lastBeat) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
    if (dataFire) remD = lastBeat ? '0 : remQ - CNT_W'(4);
  end

  // Output register next value: header, payload beat, bubble or hold
  always_comb begin
    pktD    = pktQ;
    validD  = validQ;
    startD  = startQ;
    endD    = endQ;
    endOffD = endOffQ;
    if (canLoad) begin
      validD  = 1'b0;
      startD  = 1'b0;
      endD    = 1'b0;
      endOffD = 2'd0;
      if (reqFire) begin
        pktD    = hdr;
        validD  = 1'b1;
        startD  = 1'b1;
        endD    = reqIsRead;
        endOffD = reqIsRead ? 2'd3 : 2'd0;
      end else if (dataFire) begin
        pktD    = bus.WR_DATA;
        validD  = 1'b1;
        endD    = lastBeat;
        endOffD = lastBeat ? 2'(remQ - CNT_W'(1)) : 2'd0;
      end
    end
  end

  assign bus.WR_REQ_READY         = reqReady;
  assign bus.WR_DATA_READY        = dataReady;
  assign bus.TXR_PKT              = pktQ;
  assign bus.TXR_PKT_VALID        = validQ;
  assign bus.TXR_PKT_START_FLAG   = startQ;
  assign bus.TXR_PKT_START_OFFSET = 2'd0;
  assign bus.TXR_PKT_END_FLAG     = endQ;
  assign bus.TXR_PKT_END_OFFSET   = endOffQ;
  assign bus.BUSY                 = (stateQ != IDLE) || validQ;
endmodule

// File: tb/tb_txr_write_packetizer.sv
// Randomized bench for txr_write_packetizer with a packet-level reference model.
module tb_txr_write_packetizer;
  localparam logic [15:0] REQ_ID  = 16'hBEEF;
  localparam int unsigned FBE_POS = 104 % 128;
  localparam int unsigned LBE_POS = 108 % 128;

  typedef struct {
    logic [63:0] addr; logic [9:0] len; logic [7:0] tag;
    logic [3:0] fbe; logic [3:0] lbe; logic isRead;
  } desc_t;
  typedef struct {
    logic valid; logic [127:0] pkt; logic startF; logic [1:0] startOff;
    logic endF; logic [1:0] endOff; int cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  txr_write_packetizer_if bus ();
  txr_write_packetizer #(
    .C_PCI_DATA_WIDTH(128), .C_MAX_LEN_DW(1024), .C_REQUESTER_ID(REQ_ID)
  ) dut (.CLK(clk), .RST_N(rst_n), .bus(bus.slave));

  desc_t        reqQ[$];
  logic [127:0] dataQ[$];
  logic [127:0] payQ[$];
  beat_t        obs[$];
  beat_t        expQ[$];
  int           reqFireCyc[$];
  int checks = 0, passes = 0;
  int cycle = 0, consumed = 0, stallViol = 0, stopConsumed = 0, readyMode = 0, gapPct = 0;
  logic  dataReadySeen = 1'b0, prevStalled = 1'b0;
  beat_t prevBeat;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic beat_ok(input beat_t a, input beat_t e);
    return (a.pkt === e.pkt) && (a.startF === e.startF) && (a.endF === e.endF) &&
           (a.startOff === 2'd0) && (!e.endF || (a.endOff === e.endOff));
  endfunction

  // Reference: one header beat, then ceil(n/4) payload beats, last flagged END
  task automatic model_packet(input desc_t d);
    beat_t b;
    int n, nb;
    n = (d.len == 10'd0) ? 1024 : int'(d.len);
    b = '{default: '0};
    b.pkt[63:0]          = {d.addr[63:2], 2'b00};
    b.pkt[74:64]         = 11'(n % 1024);
    b.pkt[78:75]         = d.isRead ? 4'h0 : 4'h1;
    b.pkt[95:80]         = REQ_ID;
    b.pkt[103:96]        = d.tag;
    b.pkt[FBE_POS +: 4]  = d.fbe;
    b.pkt[LBE_POS +: 4]  = (n == 1) ? 4'h0 : d.lbe;
    b.startF = 1'b1;
    b.endF   = d.isRead;
    b.endOff = d.isRead ? 2'd3 : 2'd0;
    expQ.push_back(b);
    if (!d.isRead) begin
      nb = (n + 3) / 4;
      for (int i = 0; i < nb; i++) begin
        b = '{default: '0};
        b.pkt    = payQ.pop_front();
        b.endF   = (i == nb - 1);
        b.endOff = (i == nb - 1) ? 2'((n - 1) % 4) : 2'd0;
        expQ.push_back(b);
      end
    end
  endtask

  task automatic add_req(input desc_t d);
    int n;
    logic [127:0] w;
    reqQ.push_back(d);
    n = (d.len == 10'd0) ? 1024 : int'(d.len);
    if (!d.isRead) begin
      for (int i = 0; i < (n + 3) / 4; i++) begin
        w = rand128();
        dataQ.push_back(w);
        payQ.push_back(w);
      end
    end
    model_packet(d);
  endtask

  function automatic desc_t rand_desc(input int len);
    desc_t d;
    d.addr = {$urandom, $urandom}; d.len = 10'(len); d.tag = 8'($urandom);
    d.fbe = 4'($urandom); d.lbe = 4'($urandom); d.isRead = 1'b0;
    return d;
  endfunction

  task automatic clear_env();
    reqQ.delete(); dataQ.delete(); payQ.delete(); obs.delete(); expQ.delete(); reqFireCyc.delete();
    consumed = 0; stallViol = 0; stopConsumed = 0; dataReadySeen = 1'b0; prevStalled = 1'b0;
    readyMode = 0; gapPct = 0;
  endtask

  task automatic drive_idle();
    bus.WR_REQ_VALID = 1'b0; bus.WR_REQ_ADDR = '0; bus.WR_REQ_LEN = '0; bus.WR_REQ_TAG = '0;
    bus.WR_REQ_FBE = '0; bus.WR_REQ_LBE = '0; bus.WR_DATA = '0; bus.WR_DATA_VALID = 1'b0;
    bus.TXR_PKT_READY = 1'b1;
`ifdef TXR_PACKETIZER_READ_REQ_EN
    bus.WR_REQ_IS_READ = 1'b0;
`endif
  endtask

  // Cycle engine: drive at negedge, sample 1ns later, record accepted beats
  task automatic run_cycles(input int targetBeats, input int maxCyc);
    beat_t cur;
    int n;
    n = 0;
    while (n < maxCyc && obs.size() < targetBeats && !(stopConsumed > 0 && consumed >= stopConsumed)) begin
      @(negedge clk);
      cycle++; n++;
      if (reqQ.size() > 0) begin
        bus.WR_REQ_VALID = 1'b1; bus.WR_REQ_ADDR = reqQ[0].addr; bus.WR_REQ_LEN = reqQ[0].len;
        bus.WR_REQ_TAG = reqQ[0].tag; bus.WR_REQ_FBE = reqQ[0].fbe; bus.WR_REQ_LBE = reqQ[0].lbe;
`ifdef TXR_PACKETIZER_READ_REQ_EN
        bus.WR_REQ_IS_READ = reqQ[0].isRead;
`endif
      end else bus.WR_REQ_VALID = 1'b0;
      if (dataQ.size() > 0 && $urandom_range(99) >= 32'(gapPct)) begin
        bus.WR_DATA_VALID = 1'b1; bus.WR_DATA = dataQ[0];
      end else begin
        bus.WR_DATA_VALID = 1'b0; bus.WR_DATA = rand128();
      end
      case (readyMode)
        0:       bus.TXR_PKT_READY = 1'b1;
        1:       bus.TXR_PKT_READY = 1'(cycle & 1);
        default: bus.TXR_PKT_READY = 1'($urandom_range(1));
      endcase
      #1;
      if (bus.WR_DATA_READY) dataReadySeen = 1'b1;
      if (bus.WR_REQ_VALID && bus.WR_REQ_READY) begin void'(reqQ.pop_front()); reqFireCyc.push_back(cycle); end
      if (bus.WR_DATA_VALID && bus.WR_DATA_READY) begin void'(dataQ.pop_front()); consumed++; end
      cur.valid = bus.TXR_PKT_VALID; cur.pkt = bus.TXR_PKT; cur.startF = bus.TXR_PKT_START_FLAG;
      cur.startOff = bus.TXR_PKT_START_OFFSET; cur.endF = bus.TXR_PKT_END_FLAG;
      cur.endOff = bus.TXR_PKT_END_OFFSET; cur.cyc = cycle;
      if (prevStalled && !(cur.valid === 1'b1 && cur.pkt === prevBeat.pkt && cur.startF === prevBeat.startF &&
          cur.endF === prevBeat.endF && cur.endOff === prevBeat.endOff)) stallViol++;
      prevStalled = bus.TXR_PKT_VALID && !bus.TXR_PKT_READY;
      if (bus.TXR_PKT_VALID && bus.TXR_PKT_READY) obs.push_back(cur);
      prevBeat = cur;
    end
  endtask

  task automatic test_reset();
    drive_idle();
    #1 rst_n = 1'b0;
    #11;
    checks++;
    if ({bus.TXR_PKT, bus.TXR_PKT_VALID, bus.TXR_PKT_START_FLAG, bus.TXR_PKT_START_OFFSET, bus.TXR_PKT_END_FLAG,
         bus.TXR_PKT_END_OFFSET, bus.WR_REQ_READY, bus.WR_DATA_READY, bus.BUSY} !== '0)
      $display("FAIL reset_outputs: got pkt=%h v=%b rr=%b dr=%b busy=%b, expected all 0",
               bus.TXR_PKT, bus.TXR_PKT_VALID, bus.WR_REQ_READY, bus.WR_DATA_READY, bus.BUSY);
    else passes++;
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (bus.WR_REQ_READY !== 1'b0) $display("FAIL reset_req_ready_pre_edge: got %b expected 0", bus.WR_REQ_READY);
    else passes++;
    @(negedge clk); #1;
    checks++;
    if (bus.WR_REQ_READY !== 1'b1) $display("FAIL reset_req_ready_post_edge: got %b expected 1", bus.WR_REQ_READY);
    else passes++;
  endtask

  task automatic test_len1();
    desc_t d;
    clear_env();
    d = rand_desc(1); d.addr = 64'h1000; d.fbe = 4'hF; d.lbe = 4'hA; d.tag = 8'h05;
    add_req(d);
    dataQ.push_back(rand128());          // surplus beat, must never be consumed
    run_cycles(2, 50);
    checks++;
    if (obs.size() != 2) $display("FAIL len1_beats: got %0d expected 2", obs.size());
    else begin
      passes++;
      checks++;
      if (obs[0].pkt[31:0] !== 32'h1000 || obs[0].pkt[74:64] !== 11'd1 || obs[0].pkt[LBE_POS +: 4] !== 4'h0)
        $display("FAIL len1_hdr_fields: got dw0=%h cnt=%0d lbe=%h expected 00001000/1/0",
                 obs[0].pkt[31:0], obs[0].pkt[74:64], obs[0].pkt[LBE_POS +: 4]);
      else passes++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (!beat_ok(obs[i], expQ[i]))
          $display("FAIL len1_beat%0d: got %h s=%b e=%b eo=%0d expected %h s=%b e=%b eo=%0d", i, obs[i].pkt,
                   obs[i].startF, obs[i].endF, obs[i].endOff, expQ[i].pkt, expQ[i].startF, expQ[i].endF, expQ[i].endOff);
        else passes++;
      end
      checks++;
      if (reqFireCyc.size() != 1 || obs[0].cyc - reqFireCyc[0] != 1)
        $display("FAIL len1_hdr_latency: got %0d expected 1", reqFireCyc.size() == 1 ? obs[0].cyc - reqFireCyc[0] : -1);
      else passes++;
    end
    run_cycles(1 << 20, 6);
    checks++;
    if (consumed != 1) $display("FAIL len1_consumed: got %0d expected 1", consumed);
    else passes++;
    checks++;
    if (bus.BUSY !== 1'b0) $display("FAIL len1_busy_idle: got %b expected 0", bus.BUSY);
    else passes++;
  endtask

  task automatic test_len6();
    clear_env();
    add_req(rand_desc(6));
    dataQ.push_back(rand128());
    run_cycles(3, 50);
    run_cycles(1 << 20, 6);
    checks++;
    if (obs.size() != 3) $display("FAIL len6_beats: got %0d expected 3", obs.size());
    else begin
      passes++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (!beat_ok(obs[i], expQ[i]))
          $display("FAIL len6_beat%0d: got %h e=%b eo=%0d expected %h e=%b eo=%0d", i, obs[i].pkt,
                   obs[i].endF, obs[i].endOff, expQ[i].pkt, expQ[i].endF, expQ[i].endOff);
        else passes++;
      end
      checks++;
      if (obs[2].endOff !== 2'd1) $display("FAIL len6_end_offset: got %0d expected 1", obs[2].endOff);
      else passes++;
    end
    checks++;
    if (consumed != 2) $display("FAIL len6_consumed: got %0d expected 2", consumed);
    else passes++;
  endtask

  task automatic test_len1024_stall();
    int bad;
    clear_env();
    readyMode = 1;
    add_req(rand_desc(0));
    run_cycles(257, 3000);
    checks++;
    if (obs.size() != 257) $display("FAIL len1024_beats: got %0d expected 257", obs.size());
    else begin
      passes++;
      bad = 0;
      for (int i = 0; i < 257; i++) begin
        checks++;
        if (!beat_ok(obs[i], expQ[i])) begin
          if (bad < 4) $display("FAIL len1024_beat%0d: got %h e=%b eo=%0d expected %h e=%b eo=%0d", i, obs[i].pkt,
                                obs[i].endF, obs[i].endOff, expQ[i].pkt, expQ[i].endF, expQ[i].endOff);
          bad++;
        end else passes++;
      end
      checks++;
      if (obs[256].endF !== 1'b1 || obs[256].endOff !== 2'd3 || obs[0].pkt[74:64] !== 11'd0)
        $display("FAIL len1024_end: got e=%b eo=%0d cnt=%0d expected 1/3/0", obs[256].endF, obs[256].endOff, obs[0].pkt[74:64]);
      else passes++;
    end
    checks++;
    if (stallViol != 0) $display("FAIL len1024_stall_stable: got %0d changes expected 0", stallViol);
    else passes++;
    checks++;
    if (consumed != 256) $display("FAIL len1024_consumed: got %0d expected 256", consumed);
    else passes++;
  endtask

  task automatic test_back_to_back();
    clear_env();
    add_req(rand_desc(4));
    add_req(rand_desc(4));
    run_cycles(4, 50);
    checks++;
    if (obs.size() != 4) $display("FAIL b2b_beats: got %0d expected 4", obs.size());
    else begin
      passes++;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (!beat_ok(obs[i], expQ[i]))
          $display("FAIL b2b_beat%0d: got %h s=%b e=%b expected %h s=%b e=%b", i, obs[i].pkt, obs[i].startF,
                   obs[i].endF, expQ[i].pkt, expQ[i].startF, expQ[i].endF);
        else passes++;
      end
      checks++;
      if (obs[3].cyc - obs[0].cyc != 3) $display("FAIL b2b_no_bubble: got span %0d expected 3", obs[3].cyc - obs[0].cyc);
      else passes++;
    end
  endtask

  task automatic test_mid_reset();
    int ends;
    clear_env();
    add_req(rand_desc(16));
    stopConsumed = 2;
    run_cycles(1 << 20, 50);
    checks++;
    if (consumed != 2) $display("FAIL midrst_pre_consumed: got %0d expected 2", consumed);
    else passes++;
    @(posedge clk); #2;
    checks++;
    if (bus.BUSY !== 1'b1) $display("FAIL midrst_busy: got %b expected 1", bus.BUSY);
    else passes++;
    rst_n = 1'b0; #1;
    checks++;
    if ({bus.TXR_PKT, bus.TXR_PKT_VALID, bus.TXR_PKT_START_FLAG, bus.TXR_PKT_START_OFFSET, bus.TXR_PKT_END_FLAG,
         bus.TXR_PKT_END_OFFSET, bus.WR_REQ_READY, bus.WR_DATA_READY, bus.BUSY} !== '0)
      $display("FAIL midrst_outputs: got pkt=%h v=%b e=%b dr=%b busy=%b, expected all 0",
               bus.TXR_PKT, bus.TXR_PKT_VALID, bus.TXR_PKT_END_FLAG, bus.WR_DATA_READY, bus.BUSY);
    else passes++;
    ends = 0;
    foreach (obs[i]) if (obs[i].endF) ends++;
    checks++;
    if (ends != 0) $display("FAIL midrst_no_end: got %0d END beats expected 0", ends);
    else passes++;
    repeat (2) @(negedge clk);
    clear_env();
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);
    add_req(rand_desc(4));
    run_cycles(2, 50);
    checks++;
    if (obs.size() != 2) $display("FAIL midrst_new_beats: got %0d expected 2", obs.size());
    else begin
      passes++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (!beat_ok(obs[i], expQ[i]))
          $display("FAIL midrst_new_beat%0d: got %h s=%b e=%b expected %h s=%b e=%b", i, obs[i].pkt, obs[i].startF,
                   obs[i].endF, expQ[i].pkt, expQ[i].startF, expQ[i].endF);
        else passes++;
      end
    end
  endtask

  task automatic test_random();
    desc_t d;
    int nDesc, bad;
    clear_env();
    readyMode = 2; gapPct = 30; nDesc = 8;
    for (int k = 0; k < nDesc; k++) begin
      d = rand_desc($urandom_range(1, 24));
`ifdef TXR_PACKETIZER_READ_REQ_EN
      d.isRead = ($urandom_range(3) == 0);
`endif
      add_req(d);
    end
    run_cycles(expQ.size(), 4000);
    checks++;
    if (obs.size() != expQ.size()) $display("FAIL random_beats: got %0d expected %0d", obs.size(), expQ.size());
    else begin
      passes++;
      bad = 0;
      for (int i = 0; i < expQ.size(); i++) begin
        checks++;
        if (!beat_ok(obs[i], expQ[i])) begin
          if (bad < 4) $display("FAIL random_beat%0d: got %h s=%b e=%b eo=%0d expected %h s=%b e=%b eo=%0d", i,
                                obs[i].pkt, obs[i].startF, obs[i].endF, obs[i].endOff,
                                expQ[i].pkt, expQ[i].startF, expQ[i].endF, expQ[i].endOff);
          bad++;
        end else passes++;
      end
    end
    checks++;
    if (stallViol != 0) $display("FAIL random_stall_stable: got %0d changes expected 0", stallViol);
    else passes++;
    checks++;
    if (consumed != int'(expQ.size()) - nDesc)
      $display("FAIL random_consumed: got %0d expected %0d", consumed, int'(expQ.size()) - nDesc);
    else passes++;
  endtask

`ifdef TXR_PACKETIZER_READ_REQ_EN
  task automatic test_read();
    desc_t d;
    clear_env();
    d = rand_desc(8); d.isRead = 1'b1;
    add_req(d);
    dataQ.push_back(rand128());
    dataQ.push_back(rand128());
    run_cycles(1, 50);
    run_cycles(1 << 20, 6);
    checks++;
    if (obs.size() != 1) $display("FAIL read_beats: got %0d expected 1", obs.size());
    else begin
      passes++;
      checks++;
      if (!beat_ok(obs[0], expQ[0]) || obs[0].endOff !== 2'd3)
        $display("FAIL read_hdr: got %h s=%b e=%b eo=%0d expected %h s=1 e=1 eo=3", obs[0].pkt, obs[0].startF,
                 obs[0].endF, obs[0].endOff, expQ[0].pkt);
      else passes++;
    end
    checks++;
    if (consumed != 0 || dataReadySeen !== 1'b0)
      $display("FAIL read_no_data: got consumed=%0d ready_seen=%b expected 0/0", consumed, dataReadySeen);
    else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_len1();
    test_len6();
    test_len1024_stall();
    test_back_to_back();
    test_mid_reset();
`ifdef TXR_PACKETIZER_READ_REQ_EN
    test_read();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/txr_write_packetizer.md
Name: txr_write_packetizer

Overview:
- Upstream neighbour of the TXR-to-RQ translation stage.
- Accepts a write-request descriptor and a separate payload stream, and emits a 128-bit TXR packet stream: one 4-DW header beat followed by payload beats.
- Drives the TXR classic interface: TXR_PKT, VALID/READY, START/END flags and offsets.
- Places FBE/LBE in the header so the downstream stage can lift them into RQ tuser.

Parameters:
- C_PCI_DATA_WIDTH, 128, datapath width in bits; only 128 is supported.
- C_MAX_LEN_DW, 1024, maximum payload in DWORDs; length field 0 encodes 1024.
- C_REQUESTER_ID, 16'h0000, requester ID inserted in header DW2[31:16].

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- WR_REQ_VALID  in  1  descriptor valid
- WR_REQ_READY  out  1  descriptor accepted when VALID&READY
- WR_REQ_ADDR  in  64  DWORD-aligned byte address; bits [1:0] ignored
- WR_REQ_LEN  in  10  payload DWORDs; 0 means 1024
- WR_REQ_TAG  in  8  request tag
- WR_REQ_FBE  in  4  first byte enables
- WR_REQ_LBE  in  4  last byte enables; forced to 0 when length is 1
- WR_DATA  in  128  payload, DW0 in bits [31:0]
- WR_DATA_VALID  in  1  payload beat valid
- WR_DATA_READY  out  1  payload beat consumed when VALID&READY
- TXR_PKT  out  128  packet beat
- TXR_PKT_VALID  out  1  beat valid
- TXR_PKT_READY  in  1  downstream ready
- TXR_PKT_START_FLAG  out  1  first beat of packet
- TXR_PKT_START_OFFSET  out  2  DW offset of packet start; always 0
- TXR_PKT_END_FLAG  out  1  last beat of packet
- TXR_PKT_END_OFFSET  out  2  DW index of last valid DW in the end beat
- BUSY  out  1  a packet is in flight

Behaviour:
- Reset (RST_N low, asynchronous): every output is 0, except WR_REQ_READY = 0 until the first clock edge after release. State = IDLE.
- Mid-packet reset: the packet is abandoned with no END flag; no further WR_DATA is consumed.
- Output stage is a single register. It loads when !TXR_PKT_VALID | TXR_PKT_READY. With VALID high and READY low, all TXR_* outputs hold stable.
- States:
  - IDLE: WR_REQ_READY = 1 when the output register can load. On VALID&READY, capture the descriptor, set the remaining-DW counter to LEN (0→1024, 11 bits), load the header beat, go to HDR.
  - HDR: header beat presented. When the header is accepted, go to DATA.
  - DATA: WR_DATA_READY = output-register-can-load. Each accepted WR_DATA beat is loaded unchanged into TXR_PKT and the counter decrements by min(4, remaining). On the beat where remaining ≤ 4: END_FLAG = 1, END_OFFSET = remaining−1, then go to IDLE.
  - If WR_DATA_VALID = 0, TXR_PKT_VALID drops (bubble). The packet continues when data returns.
- Header beat:
  - DW0-1 = {ADDR[63:2], 2'b00}.
  - DW2[10:0] = DW count (1024 encoded as 0).
  - DW2[14:11] = 4'b0001 (memory write).
  - DW2[31:16] = C_REQUESTER_ID.
  - DW3[7:0] = tag.
  - FBE/LBE at bit positions UPKT_TXR_FBE_I/UPKT_TXR_LBE_I modulo 128.
  - START_FLAG = 1, START_OFFSET = 0, END_FLAG = 0.
- Total beats per packet = 1 + ceil(len/4). Latency from descriptor accept to header VALID = 1 cycle.
- Back-to-back: a new descriptor may be accepted in the same cycle the previous end beat is accepted (IDLE is entered combinationally for READY). No dead cycle between packets.
- Surplus WR_DATA beyond a packet's length is never consumed. Excess DWs within the final beat are passed through unmasked; END_OFFSET defines validity.
- BUSY = state != IDLE | TXR_PKT_VALID.

Optional Feature:
- Macro TXR_PACKETIZER_READ_REQ_EN.
- When defined: adds input WR_REQ_IS_READ (1 bit).
  - Read descriptors emit a header-only packet: DW2[14:11] = 4'b0000, START_FLAG = END_FLAG = 1, END_OFFSET = 3.
  - No WR_DATA is consumed; state returns to IDLE after header accept.
- When undefined: the port is absent and all descriptors are writes.

Test Plan:
- Write LEN=1, ADDR=0x1000, FBE=F, TAG=0x05 → 2 beats:
  - Header: DW0 = 0x00001000, DW2[10:0] = 1, LBE = 0.
  - Data beat: END_FLAG = 1, END_OFFSET = 0.
- Write LEN=6 → header plus 2 data beats; second beat END_OFFSET = 1; exactly 2 WR_DATA beats consumed.
- LEN=0 (1024 DW) with TXR_PKT_READY toggling every other cycle → 257 beats, outputs stable while stalled, END on beat 257 with END_OFFSET = 3.
- Two LEN=4 descriptors presented back-to-back with continuous data and ready → 4 beats in 4 consecutive cycles, no bubble.
- RST_N asserted after 2 of 4 data beats (LEN=16) → all outputs 0 asynchronously; after release, a new LEN=4 request yields a clean START header.
- With TXR_PACKETIZER_READ_REQ_EN: read LEN=8 → single beat, START = END = 1, END_OFFSET = 3, WR_DATA_READY stays 0.
